// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared event encoding and key-tracking state for the IR key controller
//
// Contents:
//   EVT_W          width of one key event ({type[1:0], code[15:0]})
//   EVT_PRESS/REPEAT/RELEASE  event type codes in bits [17:16]
//   key_state_t    key-tracking state machine encoding
//   mk_evt()       packs a type and a code into one event word
package ir_pkg;

  localparam int EVT_W = 18;

  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_REPEAT  = 2'b10;
  localparam logic [1:0] EVT_RELEASE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } key_state_t;

  function automatic logic [EVT_W-1:0] mk_evt(input logic [1:0] kind, input logic [15:0] code);
    return {kind, code};
  endfunction

endpackage

// File: rtl/ir_evt_fifo.sv
// rtl/ir_evt_fifo.sv - small synchronous FIFO with flush and sticky overflow flag
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   flush          clears both pointers; the overflow flag is kept
//   wr, wdata      write request and data
//   rd             pop request (ignored when empty)
//   ovf_clr        clears the sticky overflow flag
//   rdata          head entry, combinational; 0 while empty
//   empty          no entries stored
//   ovf            sticky: a write was discarded because the FIFO was full
module ir_evt_fifo #(
  parameter int WIDTH   = 18,
  parameter int FIFO_AW = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             ovf
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

  assign pop  = rd & ~empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign push = wr & (~full | pop);
  assign drop = wr & full & ~pop;

  assign rdata = empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      // A new drop wins over a clear in the same cycle.
      if (drop && !flush) ovf <= 1'b1;
      else if (ovf_clr)   ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/ir_key_ctrl.sv
// rtl/ir_key_ctrl.sv - turns ir_rcv code/ack/count into buffered PRESS/REPEAT/RELEASE events
//
// Ports:
//   clk27, reset_n  27 MHz clock, asynchronous active-low reset
//   en              block enable; 0 flushes the event FIFO and holds tracking idle
//   ir_code         current receiver code, 0 = no key
//   ir_code_ack     1-cycle strobe for a new valid frame
//   ir_code_cnt     receiver frame/repeat counter
//   evt_valid       event FIFO not empty
//   evt_data        head event {type[1:0], code[15:0]}
//   evt_rd          pop strobe
//   evt_ovf         sticky: an event was dropped on a full FIFO
//   ovf_clr         clears evt_ovf
module ir_key_ctrl
  import ir_pkg::*;
#(
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2,
  parameter int FIFO_AW      = 2
) (
  input  logic             clk27,
  input  logic             reset_n,
  input  logic             en,
  input  logic [15:0]      ir_code,
  input  logic             ir_code_ack,
  input  logic [7:0]       ir_code_cnt,
  output logic             evt_valid,
  output logic [EVT_W-1:0] evt_data,
  input  logic             evt_rd,
  output logic             evt_ovf,
  input  logic             ovf_clr
);

  localparam logic [7:0] DELAY8 = 8'(REPEAT_DELAY);
  localparam logic [7:0] RATE8  = 8'(REPEAT_RATE);

  key_state_t       state;
  logic [15:0]      cur_code;
  logic [7:0]       prev_cnt;
  logic [7:0]       rep_base;
  logic             pend_press;
  logic             push_vld;
  logic [EVT_W-1:0] push_evt;

  logic             cnt_step;
  logic [7:0]       cnt_diff;
  logic             fifo_empty;

  // A count of 0 is the receiver's "no frame yet" value and never counts as a step.
  assign cnt_step = (ir_code_cnt != prev_cnt) && (ir_code_cnt != 8'd0);
  // 8-bit modular difference makes the 255 -> 0 -> 1 wrap transparent.
  assign cnt_diff = ir_code_cnt - rep_base;

  // Decisions are registered into push_vld/push_evt and written one edge later.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cur_code   <= '0;
      prev_cnt   <= '0;
      rep_base   <= '0;
      pend_press <= 1'b0;
      push_vld   <= 1'b0;
      push_evt   <= '0;
    end else begin
      prev_cnt <= ir_code_cnt;
      push_vld <= 1'b0;
      if (!en) begin
        state      <= ST_IDLE;
        pend_press <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ir_code_ack && ir_code != 16'd0) begin
              push_vld <= 1'b1;
              push_evt <= mk_evt(EVT_PRESS, ir_code);
              cur_code <= ir_code;
              state    <= ST_PRESSED;
            end
          end
          ST_PRESSED, ST_HELD: begin
            if (pend_press) begin
              // Second half of a key change: the RELEASE went out last cycle.
              push_vld   <= 1'b1;
              push_evt   <= mk_evt(EVT_PRESS, cur_code);
              pend_press <= 1'b0;
              state      <= ST_PRESSED;
            end else if (ir_code == 16'd0) begin
              push_vld <= 1'b1;
              push_evt <= mk_evt(EVT_RELEASE, cur_code);
              state    <= ST_IDLE;
            end else if (ir_code_ack && ir_code != cur_code) begin
              push_vld   <= 1'b1;
              push_evt   <= mk_evt(EVT_RELEASE, cur_code);
              pend_press <= 1'b1;
              cur_code   <= ir_code;
            end else if (ir_code_ack) begin
              // Same key re-acked inside the release window: no event.
            end else if (cnt_step) begin
              if (state == ST_PRESSED && ir_code_cnt == DELAY8) begin
                push_vld <= 1'b1;
                push_evt <= mk_evt(EVT_REPEAT, cur_code);
                rep_base <= ir_code_cnt;
                state    <= ST_HELD;
              end else if (state == ST_HELD && cnt_diff == RATE8) begin
                push_vld <= 1'b1;
                push_evt <= mk_evt(EVT_REPEAT, cur_code);
                rep_base <= ir_code_cnt;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  ir_evt_fifo #(
    .WIDTH   (EVT_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk27),
    .reset_n (reset_n),
    .flush   (~en),
    .wr      (push_vld & en),
    .wdata   (push_evt),
    .rd      (evt_rd),
    .ovf_clr (ovf_clr),
    .rdata   (evt_data),
    .empty   (fifo_empty),
    .ovf     (evt_ovf)
  );

  assign evt_valid = ~fifo_empty;

endmodule

// File: doc/ir_key_ctrl.md
Name: ir_key_ctrl

Overview:
- Sits between ir_rcv and the CPU (PIO/register interface).
- Turns the raw ir_code / ir_code_ack / ir_code_cnt outputs into discrete key events: PRESS, REPEAT (scheduled auto-repeat) and RELEASE.
- Events are buffered in a small FIFO that the CPU drains at its own pace, so short polling gaps lose no key presses.

Parameters:
- REPEAT_DELAY, default 8: ir_code_cnt value at which the first REPEAT is issued. Legal range 2..255.
- REPEAT_RATE, default 2: number of ir_code_cnt increments between subsequent REPEATs. Legal range 1..255.
- FIFO_AW, default 2: log2 of FIFO depth (default depth 4).

Ports:
- clk27  in  1  27 MHz clock.
- reset_n  in  1  Reset, asynchronous, active-low.
- en  in  1  Block enable. 0 = flush and hold idle.
- ir_code  in  16  Current code from the receiver; 0 means no key.
- ir_code_ack  in  1  1-cycle strobe: new valid frame.
- ir_code_cnt  in  8  Frame/repeat counter from the receiver.
- evt_valid  out  1  FIFO not empty.
- evt_data  out  18  Head event: [17:16] type (01 PRESS, 10 REPEAT, 11 RELEASE), [15:0] code.
- evt_rd  in  1  Pop strobe. Ignored when evt_valid=0.
- evt_ovf  out  1  Sticky flag: an event was dropped because the FIFO was full.
- ovf_clr  in  1  Clears evt_ovf.

Behaviour:
- Reset: evt_valid=0, evt_data=0, evt_ovf=0, FIFO pointers=0, state=IDLE, cur_code=0, prev_cnt=0, rep_base=0, pend_press=0.
- All inputs are synchronous to clk27; no input synchronisers are needed.
- cnt_step = (ir_code_cnt != prev_cnt) & (ir_code_cnt != 0). prev_cnt is registered every cycle.
- State machine: IDLE, PRESSED, HELD.
- IDLE:
  - ir_code_ack & ir_code!=0 → push PRESS(ir_code), cur_code<=ir_code, go to PRESSED.
- PRESSED:
  - cnt_step & ir_code_cnt==REPEAT_DELAY → push REPEAT(cur_code), rep_base<=ir_code_cnt, go to HELD.
- HELD:
  - cnt_step & (ir_code_cnt - rep_base) mod 256 == REPEAT_RATE → push REPEAT, rep_base<=ir_code_cnt.
  - Counter wrap 255→0→1 is handled by the 8-bit modular subtraction.
  - If ir_code_cnt falls below rep_base without the modular difference matching, no REPEAT is issued.
- PRESSED/HELD, ir_code==0 → push RELEASE(cur_code), go to IDLE.
  - Release takes priority over a repeat in the same cycle.
- PRESSED/HELD, ir_code_ack with ir_code!=0 and !=cur_code:
  - This cycle: push RELEASE(old cur_code), set pend_press, cur_code<=ir_code.
  - Next cycle: push PRESS(cur_code), clear pend_press, state=PRESSED.
- PRESSED/HELD, ir_code_ack with ir_code==cur_code: no event (a same-key re-press within the release window). Stay in the current state.
- Event-to-output latency:
  - An event decided from inputs sampled at edge N is written at edge N+1.
  - evt_valid rises after edge N+1 when the FIFO was empty.
  - evt_data is the combinational read of the head entry.
- At most one push per cycle, by construction.
- FIFO:
  - Depth 2^FIFO_AW, pointers FIFO_AW+1 bits wide. Full = MSBs differ and LSBs equal.
  - Pop on evt_rd & evt_valid.
  - Push while full and no pop in the same cycle → event dropped, evt_ovf<=1.
  - Push and pop in the same cycle while full → both succeed, no overflow.
  - Push and pop in the same cycle while empty → impossible (evt_valid=0, so the pop is ignored).
- ovf_clr and a new overflow in the same cycle → evt_ovf stays 1.
- en=0:
  - Flush the FIFO (pointers=0), state=IDLE, pend_press=0, and no pushes.
  - evt_ovf is retained.
  - On en 0→1, tracking restarts from IDLE; a held key generates PRESS only on its next ack.
- Asynchronous reset mid-operation clears everything immediately. No event is emitted for the key that was held.

Decomposition:
- Shared package (ir_pkg): event-type constants EVT_PRESS=2'b01, EVT_REPEAT=2'b10, EVT_RELEASE=2'b11, and the event width 18.
- One sub-module: ir_evt_fifo (generic synchronous FIFO with width, FIFO_AW, full/empty and overflow reporting).
- The state machine and repeat scheduler stay in ir_key_ctrl.

Test Plan:
1. Press and hold:
   - Stimulus: ack with code 0x1A2B, then ir_code_cnt steps 2..13.
   - Response: PRESS(0x1A2B), REPEAT at cnt=8, then at cnt=10 and 12. FIFO holds exactly 4 events (depth 4), evt_ovf=0.
2. Release:
   - Stimulus: after case 1 with 4 pops, drop ir_code to 0.
   - Response: single RELEASE(0x1A2B), evt_data=18'h31A2B.
3. Key change:
   - Stimulus: held 0x1111, then ack with 0x2222.
   - Response: RELEASE(0x1111) in cycle N+1 and PRESS(0x2222) in cycle N+2.
4. Overflow:
   - Stimulus: 6 presses of distinct codes with no reads.
   - Response: first 4 events retained, evt_ovf=1. ovf_clr → evt_ovf=0.
   - Same-cycle pop+push while full → no overflow.
5. Wrap:
   - Setup: REPEAT_RATE=3, HELD with rep_base=254.
   - Stimulus: cnt steps 255, 0, 1.
   - Response: REPEAT at cnt=1 only (cnt=0 step ignored).
6. Enable/reset:
   - Stimulus: en=0 with 3 queued events.
   - Response: evt_valid=0 next cycle.
   - Stimulus: reset_n pulse mid-HELD.
   - Response: all outputs 0, and no RELEASE afterwards.
